branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving the PC and target width in bits (minimum 32).
REQ-002 SHALL have parameter BHT_IDX_W, default 6, giving log2 of the BHT entry count.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, giving the return-stack entry count (a power of 2).
REQ-004 SHALL have clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have io_req_valid / io_req_ready, in/out, 1 bit each: fetch request handshake.
REQ-007 SHALL have io_req_pc, in, ADDR_W bits, and io_req_inst, in, 32 bits: fetched PC and instruction.
REQ-008 SHALL have io_resp_valid / io_resp_ready, out/in, 1 bit each: prediction response handshake.
REQ-009 SHALL have io_resp_taken, out, 1 bit: redirect fetch to io_resp_target.
REQ-010 SHALL have io_resp_target, out, ADDR_W bits: predicted target.
REQ-011 SHALL have io_resp_jump, out, 1 bit: unpredictable control transfer; fetch stalls until EXU resolves it.
REQ-012 SHALL have io_upd_valid, io_upd_pc (ADDR_W bits) and io_upd_taken, all inputs: EXU branch resolution.
REQ-013 SHALL have io_flush, input, 1 bit: discard the held response.

Function
REQ-014 SHALL accept a request when io_req_valid & io_req_ready, with io_req_ready = !io_flush & (!io_resp_valid | io_resp_ready).
REQ-015 SHALL present the response registered exactly 1 cycle after acceptance and hold it stable until io_resp_ready.
REQ-016 SHALL support back-to-back acceptance every cycle while io_resp_ready stays high.
REQ-017 SHALL decode JAL as opcode 0x6F; imm = {inst[31],inst[19:12],inst[20],inst[30:21],0}, sign-extended to ADDR_W.
REQ-018 SHALL decode B-type as opcode 0x63 with funct3 in {0,1,4,5,6,7}; imm = {inst[31],inst[7],inst[30:25],inst[11:8],0}, sign-extended to ADDR_W.
REQ-019 SHALL compute target = pc + imm modulo 2^ADDR_W, so wrap-around is silent.
REQ-020 SHALL predict JAL as always taken.
REQ-021 SHALL predict a B-type branch taken iff BHT[pc[BHT_IDX_W+1:2]] >= 2; the BHT holds 2-bit counters.
REQ-022 SHALL assert io_resp_jump=1, taken=0 for ECALL (0x00000073), EBREAK (0x00100073), MRET (0x30200073), and every JALR (opcode 0x67, funct3 0) not handled by REQ-031.
REQ-023 SHALL drive taken=0, jump=0, target=0 for all other instructions.
REQ-024 SHALL, on io_upd_valid, increment (io_upd_taken=1) or decrement the counter at io_upd_pc[BHT_IDX_W+1:2], saturating at 3 and 0.
REQ-025 SHALL, when an update and a lookup hit the same index in the same cycle, give the lookup the pre-update counter value.
REQ-026 SHALL, on io_flush, clear io_resp_valid the next cycle and accept no request in the flush cycle; flush has priority over io_resp_ready.

Reset
REQ-027 SHALL, on reset, set io_resp_valid, taken, jump and target to 0.
REQ-028 SHALL, on reset, set every BHT counter to 1 (weakly not-taken) and empty the RAS.
REQ-029 SHALL give reset priority over a simultaneous request, update or flush; an in-flight response is dropped.

Configuration
REQ-030 SHALL compile a RAS of RAS_DEPTH entries when macro BPU_RAS_EN is defined.
REQ-031 SHALL, with BPU_RAS_EN, handle calls and returns as follows:
- Call: JAL or JALR with rd=x1 pushes pc+4 on acceptance.
- Return: inst 0x00008067 with a non-empty RAS gives taken=1, target=top, jump=0, and pops.
- Empty-RAS return: follows REQ-022.
- Full push: overwrites the oldest entry with a circular pointer; the count saturates at RAS_DEPTH.
- Flush: RAS state is not repaired.
REQ-032 SHALL, without BPU_RAS_EN, contain no RAS storage and treat returns per REQ-022.

Verification
REQ-033 SHALL cover: pc=0x80000000, inst=0xFF9FF06F (jal -8) -> next cycle valid=1, taken=1, target=0x7FFFFFF8.
REQ-034 SHALL cover: after reset, beq at pc=0x80000010, offset -16 -> taken=0; after two upd_taken=1 at that pc -> taken=1, target=0x80000000.
REQ-035 SHALL cover: counter at 3 with upd_taken=1 stays 3; counter at 0 with upd_taken=0 stays 0; simultaneous update+lookup returns the old value.
REQ-036 SHALL cover: resp_ready=0 for 3 cycles -> response held stable and req_ready=0; then io_flush=1 -> resp_valid=0 next cycle and the request is not accepted.
REQ-037 SHALL cover: inst 0x00000073 and 0x30200073 -> jump=1, taken=0.
REQ-038 SHALL cover: with BPU_RAS_EN, jal x1 at 0x80000100 then ret -> taken=1, target=0x80000104; a 5th nested call at depth 4 overwrites the oldest entry; ret on empty RAS -> jump=1.

Source files
------------

// File: rtl/branch_predictor.sv
// Static/dynamic fetch-stage branch predictor: JAL/B-type decode, 2-bit BHT, optional RAS.
// Define BPU_RAS_EN to build the return-address stack; without it returns stall fetch like any JALR.
module branch_predictor #(
  parameter int ADDR_W    = 32,
  parameter int BHT_IDX_W = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_req_pc,
  input  logic [31:0]       io_req_inst,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic              io_resp_taken,
  output logic [ADDR_W-1:0] io_resp_target,
  output logic              io_resp_jump,
  input  logic              io_upd_valid,
  input  logic [ADDR_W-1:0] io_upd_pc,
  input  logic              io_upd_taken,
  input  logic              io_flush
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_RET    = 32'h0000_8067;

  logic              resp_valid_reg;
  logic              resp_taken_reg;
  logic              resp_jump_reg;
  logic [ADDR_W-1:0] resp_target_reg;

  logic [1:0] bht_reg [BHT_N];

  logic                 accept;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 is_jal;
  logic                 is_branch;
  logic                 is_jalr;
  logic                 is_system;
  logic                 is_ret;
  logic                 ras_hit;
  logic [ADDR_W-1:0]    ras_top;
  logic [ADDR_W-1:0]    imm_j;
  logic [ADDR_W-1:0]    imm_b;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 pred_taken;
  logic                 pred_jump;
  logic [ADDR_W-1:0]    pred_target;
  logic                 unused_upd_bits;

  assign io_req_ready   = !io_flush && (!resp_valid_reg || io_resp_ready);
  assign accept         = io_req_valid && io_req_ready;
  assign io_resp_valid  = resp_valid_reg;
  assign io_resp_taken  = resp_taken_reg;
  assign io_resp_jump   = resp_jump_reg;
  assign io_resp_target = resp_target_reg;

  assign opcode    = io_req_inst[6:0];
  assign funct3    = io_req_inst[14:12];
  assign is_jal    = (opcode == 7'h6F);
  assign is_branch = (opcode == 7'h63) && (funct3 != 3'd2) && (funct3 != 3'd3);
  assign is_jalr   = (opcode == 7'h67) && (funct3 == 3'd0);
  assign is_system = (io_req_inst == INST_ECALL) || (io_req_inst == INST_EBREAK) ||
                     (io_req_inst == INST_MRET);
  assign is_ret    = (io_req_inst == INST_RET);

  assign imm_j = {{(ADDR_W-21){io_req_inst[31]}}, io_req_inst[31], io_req_inst[19:12],
                  io_req_inst[20], io_req_inst[30:21], 1'b0};
  assign imm_b = {{(ADDR_W-13){io_req_inst[31]}}, io_req_inst[31], io_req_inst[7],
                  io_req_inst[30:25], io_req_inst[11:8], 1'b0};

  assign lookup_idx      = io_req_pc[BHT_IDX_W+1:2];
  assign upd_idx         = io_upd_pc[BHT_IDX_W+1:2];
  assign unused_upd_bits = ^{io_upd_pc[ADDR_W-1:BHT_IDX_W+2], io_upd_pc[1:0]};

`ifdef BPU_RAS_EN
  localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_PTR_W:0] RAS_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0]    ras_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_ptr_reg;
  logic [RAS_PTR_W:0]   ras_cnt_reg;
  logic [RAS_PTR_W-1:0] ras_top_ptr;
  logic                 is_call;

  // ras_ptr_reg points at the next free slot; the pointer wraps, so a push when full
  // lands on the oldest entry.
  assign ras_top_ptr = ras_ptr_reg - 1'b1;
  assign ras_top     = ras_mem[ras_top_ptr];
  assign ras_hit     = is_ret && (ras_cnt_reg != '0);
  assign is_call     = (is_jal || is_jalr) && (io_req_inst[11:7] == 5'd1);

  always_ff @(posedge clock) begin
    if (accept && is_call) begin
      ras_mem[ras_ptr_reg] <= io_req_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
    end else if (accept && is_call) begin
      ras_ptr_reg <= ras_ptr_reg + 1'b1;
      if (ras_cnt_reg != RAS_FULL) begin
        ras_cnt_reg <= ras_cnt_reg + 1'b1;
      end
    end else if (accept && ras_hit) begin
      ras_ptr_reg <= ras_top_ptr;
      ras_cnt_reg <= ras_cnt_reg - 1'b1;
    end
  end
`else
  assign ras_hit = 1'b0;
  assign ras_top = '0;
`endif

  // A RAS hit is checked before the generic JALR case since a return is itself a JALR.
  always_comb begin
    pred_taken  = 1'b0;
    pred_jump   = 1'b0;
    pred_target = '0;
    if (is_jal) begin
      pred_taken  = 1'b1;
      pred_target = io_req_pc + imm_j;
    end else if (is_branch) begin
      pred_taken  = bht_reg[lookup_idx][1];
      pred_target = io_req_pc + imm_b;
    end else if (ras_hit) begin
      pred_taken  = 1'b1;
      pred_target = ras_top;
    end else if (is_jalr || is_system) begin
      pred_jump = 1'b1;
    end
  end

  // Lookups read the array combinationally before this edge's write, so a same-cycle
  // update to the same index is not visible to the lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_reg[i] <= 2'd1;
      end
    end else if (io_upd_valid) begin
      if (io_upd_taken && (bht_reg[upd_idx] != 2'd3)) begin
        bht_reg[upd_idx] <= bht_reg[upd_idx] + 2'd1;
      end else if (!io_upd_taken && (bht_reg[upd_idx] != 2'd0)) begin
        bht_reg[upd_idx] <= bht_reg[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_reg  <= 1'b0;
      resp_taken_reg  <= 1'b0;
      resp_jump_reg   <= 1'b0;
      resp_target_reg <= '0;
    end else if (io_flush) begin
      resp_valid_reg <= 1'b0;
    end else if (accept) begin
      resp_valid_reg  <= 1'b1;
      resp_taken_reg  <= pred_taken;
      resp_jump_reg   <= pred_jump;
      resp_target_reg <= pred_target;
    end else if (io_resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed spec cases plus random traffic against a
// queue/array reference model. Define BPU_RAS_EN here and in the RTL to exercise the RAS.
module tb_branch_predictor;
  localparam int AW = 32;
  localparam int IW = 6;
  localparam int RD = 4;
`ifdef BPU_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_req_valid = 1'b0;
  logic          io_req_ready;
  logic [AW-1:0] io_req_pc = '0;
  logic [31:0]   io_req_inst = '0;
  logic          io_resp_valid;
  logic          io_resp_ready = 1'b1;
  logic          io_resp_taken;
  logic [AW-1:0] io_resp_target;
  logic          io_resp_jump;
  logic          io_upd_valid = 1'b0;
  logic [AW-1:0] io_upd_pc = '0;
  logic          io_upd_taken = 1'b0;
  logic          io_flush = 1'b0;

  branch_predictor #(.ADDR_W(AW), .BHT_IDX_W(IW), .RAS_DEPTH(RD)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_pc(io_req_pc), .io_req_inst(io_req_inst),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_taken(io_resp_taken), .io_resp_target(io_resp_target),
    .io_resp_jump(io_resp_jump),
    .io_upd_valid(io_upd_valid), .io_upd_pc(io_upd_pc), .io_upd_taken(io_upd_taken),
    .io_flush(io_flush)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            id;
    logic [AW-1:0] pc;
    logic          taken;
    logic          jump;
    logic [AW-1:0] target;
    logic          chk_target;
  } exp_t;

  exp_t          exp_q[$];
  int            bht[1 << IW];
  logic [AW-1:0] ras_q[$];
  logic          mdl_valid = 1'b0;
  int            txn = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int rd, input int off);
    logic [20:0] im;
    logic [4:0]  r;
    im = off[20:0];
    r  = rd[4:0];
    return {im[20], im[10:1], im[11], im[19:12], r, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_b(input int f3, input int off);
    logic [12:0] im;
    logic [2:0]  f;
    im = off[12:0];
    f  = f3[2:0];
    return {im[12], im[10:5], 5'd0, 5'd0, f, im[4:1], im[11], 7'h63};
  endfunction

  // Offsets rebuilt as signed integers from the immediate bit scatter.
  function automatic int j_off(input logic [31:0] inst);
    int v;
    v = (int'(inst[31]) << 20) + (int'(inst[19:12]) << 12) + (int'(inst[20]) << 11) +
        (int'(inst[30:21]) << 1);
    return inst[31] ? v - (1 << 21) : v;
  endfunction

  function automatic int b_off(input logic [31:0] inst);
    int v;
    v = (int'(inst[31]) << 12) + (int'(inst[7]) << 11) + (int'(inst[30:25]) << 5) +
        (int'(inst[11:8]) << 1);
    return inst[31] ? v - (1 << 13) : v;
  endfunction

  task automatic predict(input logic [AW-1:0] pc, input logic [31:0] inst, output exp_t e);
    int  op, f3, rd, idx;
    bit  sys;
    op  = int'(inst[6:0]);
    f3  = int'(inst[14:12]);
    rd  = int'(inst[11:7]);
    idx = int'((pc / 4) % (1 << IW));
    sys = (inst == 32'h0000_0073) || (inst == 32'h0010_0073) || (inst == 32'h3020_0073);
    e.id = txn; e.pc = pc; e.taken = 0; e.jump = 0; e.target = '0; e.chk_target = 1;
    txn++;
    if (op == 'h6F) begin
      e.taken  = 1;
      e.target = pc + AW'(j_off(inst));
    end else if (op == 'h63 && f3 != 2 && f3 != 3) begin
      e.taken      = (bht[idx] >= 2);
      e.target     = pc + AW'(b_off(inst));
      e.chk_target = e.taken;
    end else if (RAS_EN && inst == 32'h0000_8067 && ras_q.size() > 0) begin
      e.taken  = 1;
      e.target = ras_q.pop_back();
    end else if ((op == 'h67 && f3 == 0) || sys) begin
      e.jump       = 1;
      e.chk_target = 0;
    end
    if (RAS_EN && (op == 'h6F || (op == 'h67 && f3 == 0)) && rd == 1) begin
      ras_q.push_back(pc + 4);
      if (ras_q.size() > RD) void'(ras_q.pop_front());
    end
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic rv, input logic [AW-1:0] pc, input logic [31:0] inst,
                     input logic rr, input logic fl, input logic uv,
                     input logic [AW-1:0] upc, input logic ut);
    logic exp_ready, acc;
    exp_t e;
    io_req_valid = rv; io_req_pc = pc; io_req_inst = inst; io_resp_ready = rr;
    io_flush = fl; io_upd_valid = uv; io_upd_pc = upc; io_upd_taken = ut;
    exp_ready = !fl && (!mdl_valid || rr);
    acc = rv && exp_ready;
    if (acc) begin
      predict(pc, inst, e);
      exp_q.push_back(e);
    end
    @(negedge clock);
    check("req_ready", 32'(io_req_ready), 32'(exp_ready));
    @(posedge clock);
    #1;
    if (uv) begin
      int idx;
      idx = int'((upc / 4) % (1 << IW));
      if (ut) bht[idx] = (bht[idx] < 3) ? bht[idx] + 1 : 3;
      else    bht[idx] = (bht[idx] > 0) ? bht[idx] - 1 : 0;
    end
    if (fl) begin
      if (mdl_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      mdl_valid = 1'b0;
    end else if (acc) begin
      mdl_valid = 1'b1;
    end else if (rr) begin
      mdl_valid = 1'b0;
    end
    check("resp_valid", 32'(io_resp_valid), 32'(mdl_valid));
  endtask

  task automatic req(input logic [AW-1:0] pc, input logic [31:0] inst);
    cyc(1, pc, inst, 1, 0, 0, '0, 0);
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic taken);
    cyc(0, '0, '0, 1, 0, 1, pc, taken);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && io_resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got valid response target=%h, expected none", io_resp_target);
      end else begin
        check($sformatf("taken#%0d", exp_q[0].id), 32'(io_resp_taken), 32'(exp_q[0].taken));
        check($sformatf("jump#%0d", exp_q[0].id), 32'(io_resp_jump), 32'(exp_q[0].jump));
        if (exp_q[0].chk_target)
          check($sformatf("target#%0d", exp_q[0].id), io_resp_target, exp_q[0].target);
        if (io_resp_ready) begin
          $display("resp #%0d pc=%h taken=%b jump=%b target=%h", exp_q[0].id, exp_q[0].pc,
                   io_resp_taken, io_resp_jump, io_resp_target);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] beq_m16;
    beq_m16 = enc_b(0, -16);
    for (int i = 0; i < (1 << IW); i++) bht[i] = 1;

    // Reset held while a request and an update are offered: both must be ignored.
    io_req_valid = 1; io_req_pc = 32'h8000_0000; io_req_inst = 32'hFF9F_F06F;
    io_upd_valid = 1; io_upd_pc = 32'h8000_0010; io_upd_taken = 1;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    io_req_valid = 0; io_upd_valid = 0;
    check("rst_valid", 32'(io_resp_valid), 0);
    check("rst_taken", 32'(io_resp_taken), 0);
    check("rst_jump", 32'(io_resp_jump), 0);
    check("rst_target", io_resp_target, 0);
    cyc(0, '0, '0, 1, 0, 0, '0, 0);

    req(32'h8000_0000, 32'hFF9F_F06F);              // jal -8 wraps below 0x80000000
    req(32'h8000_0010, beq_m16);                    // counter 1: not taken
    upd(32'h8000_0010, 1);
    upd(32'h8000_0010, 1);
    req(32'h8000_0010, beq_m16);                    // counter 3: taken to 0x80000000
    upd(32'h8000_0010, 1);                          // saturate high
    upd(32'h8000_0010, 0);
    upd(32'h8000_0010, 0);
    req(32'h8000_0010, beq_m16);                    // back to 1: not taken
    repeat (3) upd(32'h8000_0010, 0);               // saturate low
    upd(32'h8000_0010, 1);
    req(32'h8000_0010, beq_m16);                    // 1: not taken
    cyc(1, 32'h8000_0010, beq_m16, 1, 0, 1, 32'h8000_0010, 1); // sees old value 1
    req(32'h8000_0010, beq_m16);                    // now 2: taken

    // Back-pressure then flush.
    cyc(1, 32'h8000_0040, enc_jal(0, 64), 0, 0, 0, '0, 0);
    repeat (3) cyc(1, 32'h8000_0044, enc_jal(0, 8), 0, 0, 0, '0, 0);
    cyc(1, 32'h8000_0044, enc_jal(0, 8), 0, 1, 0, '0, 0);
    cyc(0, '0, '0, 1, 0, 0, '0, 0);

    req(32'h8000_0050, 32'h0000_0073);              // ecall
    req(32'h8000_0054, 32'h0010_0073);              // ebreak
    req(32'h8000_0058, 32'h3020_0073);              // mret
    req(32'h8000_005C, 32'h0002_8067);              // jalr x0, 0(x5)
    req(32'h8000_0060, 32'h0000_8067);              // ret with empty/no RAS
    req(32'h8000_0064, 32'h0000_0033);              // add: no control transfer
    req(32'h8000_0068, enc_b(2, 8));                // funct3 2 is not a branch
    req(32'hFFFF_FFF0, enc_jal(0, 32));             // target wraps past 2^32

`ifdef BPU_RAS_EN
    req(32'h8000_0100, enc_jal(1, 256));
    req(32'h8000_0200, 32'h0000_8067);              // ret -> 0x80000104
    for (int k = 0; k < 5; k++) req(32'h8000_1000 + 32'(16 * k), enc_jal(1, 64));
    for (int k = 0; k < 5; k++) req(32'h8000_2000 + 32'(4 * k), 32'h0000_8067);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] pc, upc;
      logic [31:0]   inst;
      logic          rr, fl;
      pc  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 12);
      upc = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
      case ($urandom_range(0, 9))
        0: inst = enc_jal($urandom_range(0, 1), int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20));
        1, 2: inst = enc_b($urandom_range(0, 7), int'($urandom_range(0, 4095)) * 2 - 4096);
        3: inst = {17'd0, 3'd0, 4'd0, 1'($urandom_range(0, 1)), 7'h67} | 32'h0000_8000;
        4: inst = 32'h0000_8067;
        5: inst = 32'h0000_0073;
        6: inst = 32'h0010_0073;
        7: inst = 32'h3020_0073;
        default: inst = $urandom;
      endcase
      rr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      if (fl) rr = 0;
      cyc(($urandom_range(0, 3) != 0), pc, inst, rr, fl, 1'($urandom_range(0, 1)), upc,
          1'($urandom_range(0, 1)));
    end

    repeat (3) cyc(0, '0, '0, 1, 0, 0, '0, 0);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
